// File: rtl/fpmul_norm_round.sv
// rtl/fpmul_norm_round.sv - FP multiply back end: normalize, denormalize, round, pack binary32, fflags
package fpmul_norm_round_pkg;
    typedef struct packed {
        logic [7:0] ctrl;
        logic [4:0] rd;
        logic       reg_write;
        logic       FP_reg_write;
    } exe_p_mux_bus_type;
endpackage

module fpmul_norm_round
    import fpmul_norm_round_pkg::*;
#(
    parameter int addr_width = 5,
    parameter int num_rds    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [num_rds-1:0]      clear,
    input  logic [9:0]              exp_i,
    input  logic [47:0]             mant_i,
    input  logic                    sign_i,
    input  logic                    is_NaN_i,
    input  logic                    is_inf_i,
    input  logic                    is_zero_i,
    input  logic                    nv_i,
    input  logic [2:0]              rm_i,
    input  logic                    P_signal_i,
    input  exe_p_mux_bus_type       pipeline_signals_i,
    output logic [31:0]             result_o,
    output logic [4:0]              fflags_o,
    output exe_p_mux_bus_type       pipeline_signals_o,
    output logic                    P_O_signal,
    output logic [addr_width-1:0]   uu_rd [0:num_rds-1],
    output logic [num_rds-1:0]      uu_reg_write,
    output logic [num_rds-1:0]      uu_FP_reg_write
);

    // ---------------- stage A: normalize / denormalize ----------------
    logic signed [10:0] e0, e1, dn;
    logic [10:0]        emax;
    logic [5:0]         lz, shl, dsh;
    logic [46:0]        m1, m2;
    logic [47:0]        lost;
    logic               st1;
    logic [10:0]        e2;

    always_comb begin
        e0   = {exp_i[9], exp_i};
        lz   = 6'd47;
        for (int i = 0; i < 47; i++) begin
            if (mant_i[i]) lz = 6'(46 - i);
        end
        emax = 11'd0;
        shl  = 6'd0;
        st1  = 1'b0;
        if (mant_i[47]) begin
            m1  = 47'(mant_i >> 1);
            st1 = mant_i[0];
            e1  = e0 + 11'sd1;
        end else begin
            // never shift the exponent below 1; the rest becomes a subnormal
            if (e0 > 11'sd1) emax = 11'(e0 - 11'sd1);
            shl = ({5'd0, lz} < emax) ? lz : emax[5:0];
            m1  = mant_i[46:0] << shl;
            e1  = e0 - $signed({5'd0, shl});
        end
        dn  = 11'sd1 - e1;
        dsh = 6'd0;
        if (e1 < 11'sd1) dsh = (dn > 11'sd48) ? 6'd48 : dn[5:0];
        {m2, lost} = {m1, 48'd0} >> dsh;
        e2 = (e1 < 11'sd1) ? 11'd0 : 11'(e1);
    end

    logic [46:0]       a_m;
    logic [10:0]       a_e;
    logic              a_st, a_sign, a_nan, a_inf, a_zero, a_nv, a_p;
    logic [2:0]        a_rm;
    exe_p_mux_bus_type a_ps;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_m <= '0; a_e <= '0; a_st <= 1'b0; a_sign <= 1'b0;
            a_nan <= 1'b0; a_inf <= 1'b0; a_zero <= 1'b0; a_nv <= 1'b0;
            a_rm <= '0; a_p <= 1'b0; a_ps <= '0;
        end else if (clear[1]) begin
            a_m <= '0; a_e <= '0; a_st <= 1'b0; a_sign <= 1'b0;
            a_nan <= 1'b0; a_inf <= 1'b0; a_zero <= 1'b0; a_nv <= 1'b0;
            a_rm <= '0; a_p <= 1'b0; a_ps <= '0;
        end else if (en) begin
            a_m    <= m2;
            a_e    <= e2;
            a_st   <= st1 | (|lost);
            a_sign <= sign_i;
            a_nan  <= is_NaN_i;
            a_inf  <= is_inf_i;
            a_zero <= is_zero_i;
            a_nv   <= nv_i;
            a_rm   <= rm_i;
            a_p    <= P_signal_i;
            a_ps   <= pipeline_signals_i;
        end
    end

    // ---------------- stage B: round and pack ----------------
    logic        g, s, inc, nx, to_inf;
    logic [23:0] sum;
    logic [10:0] base, exp_r;
    logic [31:0] res_n;
    logic [4:0]  flg_n;

    always_comb begin
        g = a_m[22];
        s = (|a_m[21:0]) | a_st;
        case (a_rm)
            3'd1:    inc = 1'b0;
            3'd2:    inc = (g | s) & a_sign;
            3'd3:    inc = (g | s) & ~a_sign;
            3'd4:    inc = g;
            default: inc = g & (s | a_m[23]);
        endcase
        sum   = {1'b0, a_m[45:23]} + {23'd0, inc};
        base  = (a_e == 11'd0 && a_m[46]) ? 11'd1 : a_e;
        exp_r = base + {10'd0, sum[23]};
        nx    = g | s;
        case (a_rm)
            3'd1:    to_inf = 1'b0;
            3'd2:    to_inf = a_sign;
            3'd3:    to_inf = ~a_sign;
            default: to_inf = 1'b1;
        endcase
        if (a_nan) begin
            res_n = 32'h7FC00000;
            flg_n = {a_nv, 4'b0};
        end else if (a_inf) begin
            res_n = {a_sign, 8'hFF, 23'd0};
            flg_n = 5'b0;
        end else if (a_zero || (a_m == 47'd0 && !a_st)) begin
            res_n = {a_sign, 31'd0};
            flg_n = 5'b0;
        end else if (exp_r >= 11'd255) begin
            res_n = to_inf ? {a_sign, 8'hFF, 23'd0} : {a_sign, 8'hFE, 23'h7FFFFF};
            flg_n = 5'b00101;
        end else begin
            res_n = {a_sign, exp_r[7:0], sum[22:0]};
            flg_n = {3'b000, nx & (exp_r[7:0] == 8'd0), nx};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_o <= '0; fflags_o <= '0; pipeline_signals_o <= '0; P_O_signal <= 1'b0;
        end else if (clear[0]) begin
            result_o <= '0; fflags_o <= '0; pipeline_signals_o <= '0; P_O_signal <= 1'b0;
        end else if (en) begin
            result_o           <= res_n;
            fflags_o           <= flg_n;
            pipeline_signals_o <= a_ps;
            P_O_signal         <= a_p;
        end
    end

    assign uu_rd[0]        = a_ps.rd;
    assign uu_rd[1]        = pipeline_signals_o.rd;
    assign uu_reg_write    = {a_ps.reg_write, pipeline_signals_o.reg_write};
    assign uu_FP_reg_write = {a_ps.FP_reg_write, pipeline_signals_o.FP_reg_write};

endmodule

// File: tb/tb_fpmul_norm_round.sv
// tb/tb_fpmul_norm_round.sv - directed vector bench for fpmul_norm_round
module tb_fpmul_norm_round;
    import fpmul_norm_round_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n, en;
    logic [1:0]        clear;
    logic [9:0]        exp_i;
    logic [47:0]       mant_i;
    logic              sign_i, is_NaN_i, is_inf_i, is_zero_i, nv_i, P_signal_i;
    logic [2:0]        rm_i;
    exe_p_mux_bus_type pipeline_signals_i, pipeline_signals_o;
    logic [31:0]       result_o;
    logic [4:0]        fflags_o;
    logic              P_O_signal;
    logic [4:0]        uu_rd [0:1];
    logic [1:0]        uu_reg_write, uu_FP_reg_write;

    fpmul_norm_round #(.addr_width(5), .num_rds(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
        .exp_i(exp_i), .mant_i(mant_i), .sign_i(sign_i),
        .is_NaN_i(is_NaN_i), .is_inf_i(is_inf_i), .is_zero_i(is_zero_i),
        .nv_i(nv_i), .rm_i(rm_i), .P_signal_i(P_signal_i),
        .pipeline_signals_i(pipeline_signals_i),
        .result_o(result_o), .fflags_o(fflags_o),
        .pipeline_signals_o(pipeline_signals_o), .P_O_signal(P_O_signal),
        .uu_rd(uu_rd), .uu_reg_write(uu_reg_write), .uu_FP_reg_write(uu_FP_reg_write)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [9:0]  e;
        logic [47:0] m;
        logic        s, nan, inf, zero, nv;
        logic [2:0]  rm;
        logic [31:0] res;
        logic [4:0]  flg;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input string n, input logic [9:0] e, input logic [47:0] m,
                       input logic s, input logic nan, input logic inf, input logic zero,
                       input logic nv, input logic [2:0] rm, input logic [31:0] res,
                       input logic [4:0] flg);
        vec_t v;
        v.name = n; v.e = e; v.m = m; v.s = s; v.nan = nan; v.inf = inf;
        v.zero = zero; v.nv = nv; v.rm = rm; v.res = res; v.flg = flg;
        vq.push_back(v);
    endtask

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", n, got, exp);
        end
    endtask

    task automatic drive(input vec_t v, input int tag);
        exp_i = v.e; mant_i = v.m; sign_i = v.s; is_NaN_i = v.nan;
        is_inf_i = v.inf; is_zero_i = v.zero; nv_i = v.nv; rm_i = v.rm;
        P_signal_i = tag[0];
        pipeline_signals_i.ctrl         = tag[7:0];
        pipeline_signals_i.rd           = tag[4:0];
        pipeline_signals_i.reg_write    = 1'b1;
        pipeline_signals_i.FP_reg_write = tag[0];
    endtask

    task automatic drive_null();
        exp_i = '0; mant_i = '0; sign_i = 0; is_NaN_i = 0; is_inf_i = 0;
        is_zero_i = 0; nv_i = 0; rm_i = '0; P_signal_i = 0; pipeline_signals_i = '0;
    endtask

    initial begin
        logic [14:0] ps_exp;
        rst_n = 0; en = 0; clear = 2'b00;
        drive_null();

        add("mul15",      10'd127, 48'h900000000000, 0,0,0,0,0, 3'd0, 32'h40100000, 5'h00);
        add("tie_rne",    10'd127, 48'h400000400000, 0,0,0,0,0, 3'd0, 32'h3F800000, 5'h01);
        add("tie_rup",    10'd127, 48'h400000400000, 0,0,0,0,0, 3'd3, 32'h3F800001, 5'h01);
        add("tie_rdn",    10'd127, 48'h400000400000, 0,0,0,0,0, 3'd2, 32'h3F800000, 5'h01);
        add("ovf_rne",    10'd300, 48'h400000000000, 0,0,0,0,0, 3'd0, 32'h7F800000, 5'h05);
        add("ovf_rtz",    10'd300, 48'h400000000000, 0,0,0,0,0, 3'd1, 32'h7F7FFFFF, 5'h05);
        add("sub_m20",   -10'sd20, 48'h400000000000, 0,0,0,0,0, 3'd0, 32'h00000004, 5'h00);
        add("sub_m30rne",-10'sd30, 48'h400000000000, 0,0,0,0,0, 3'd0, 32'h00000000, 5'h03);
        add("sub_m30rup",-10'sd30, 48'h400000000000, 0,0,0,0,0, 3'd3, 32'h00000001, 5'h03);
        add("nan_nv",     10'd127, 48'h400000000000, 0,1,0,0,1, 3'd0, 32'h7FC00000, 5'h10);
        add("inf_neg",    10'd127, 48'h400000000000, 1,0,1,0,0, 3'd0, 32'hFF800000, 5'h00);
        add("zero_neg",   10'd127, 48'h400000000000, 1,0,0,1,0, 3'd0, 32'h80000000, 5'h00);
        add("ovf_rdn_n",  10'd300, 48'h400000000000, 1,0,0,0,0, 3'd2, 32'hFF800000, 5'h05);
        add("ovf_rup_n",  10'd300, 48'h400000000000, 1,0,0,0,0, 3'd3, 32'hFF7FFFFF, 5'h05);
        add("tie_rmm",    10'd127, 48'h400000400000, 0,0,0,0,0, 3'd4, 32'h3F800001, 5'h01);
        add("lnorm_half", 10'd127, 48'h200000000000, 0,0,0,0,0, 3'd0, 32'h3F000000, 5'h00);
        add("carry_up",   10'd127, 48'h7FFFFFC00000, 0,0,0,0,0, 3'd0, 32'h40000000, 5'h01);
        add("mant_zero",  10'd127, 48'h000000000000, 1,0,0,0,0, 3'd0, 32'h80000000, 5'h00);
        add("rm5_as_rne", 10'd127, 48'h400000C00000, 0,0,0,0,0, 3'd5, 32'h3F800002, 5'h01);
        add("nan_quiet",  10'd127, 48'h400000000000, 0,1,0,0,0, 3'd0, 32'h7FC00000, 5'h00);

        repeat (2) @(negedge clk);
        chk("rst_result", result_o, 32'h0);
        chk("rst_fflags", {27'd0, fflags_o}, 32'h0);
        chk("rst_uu_rw",  {30'd0, uu_reg_write}, 32'h0);
        chk("rst_uu_rd0", {27'd0, uu_rd[0]}, 32'h0);
        chk("rst_ps_o",   {17'd0, pipeline_signals_o}, 32'h0);
        rst_n = 1; en = 1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i], i + 1);
            @(negedge clk);
            @(negedge clk);
            ps_exp = {8'(i + 1), 5'(i + 1), 1'b1, 1'((i + 1) % 2)};
            chk({vq[i].name, "_res"}, result_o, vq[i].res);
            chk({vq[i].name, "_flg"}, {27'd0, fflags_o}, {27'd0, vq[i].flg});
            chk({vq[i].name, "_ps"},  {17'd0, pipeline_signals_o}, {17'd0, ps_exp});
            chk({vq[i].name, "_p"},   {31'd0, P_O_signal}, {31'd0, 1'((i + 1) % 2)});
        end

        // back-to-back issue with en dropping
        @(negedge clk); drive(vq[0], 3);
        @(negedge clk); drive(vq[1], 9);
        @(negedge clk); en = 0; drive(vq[4], 5);
        chk("b2b_op1", result_o, 32'h40100000);
        @(negedge clk);
        chk("hold_res",  result_o, 32'h40100000);
        chk("hold_rd0",  {27'd0, uu_rd[0]}, 32'd9);
        chk("hold_rd1",  {27'd0, uu_rd[1]}, 32'd3);
        en = 1;
        @(negedge clk);
        chk("b2b_op2",     result_o, 32'h3F800000);
        chk("b2b_op2_flg", {27'd0, fflags_o}, 32'h01);
        @(negedge clk);
        chk("b2b_op3", result_o, 32'h7F800000);

        // clear[1] kills an issued op while en is low
        drive(vq[6], 7);
        @(negedge clk);
        chk("clrA_rw_before", {31'd0, uu_reg_write[1]}, 32'd1);
        chk("clrA_rd_before", {27'd0, uu_rd[0]}, 32'd7);
        en = 0; clear = 2'b10;
        @(negedge clk);
        chk("clrA_rw_after", {30'd0, uu_reg_write}, 32'b01);
        chk("clrA_rd_after", {27'd0, uu_rd[0]}, 32'd0);
        chk("clrA_out_hold", result_o, 32'h7F800000);
        clear = 2'b00; en = 1; drive_null();
        @(negedge clk);
        chk("clrA_never_res", result_o, 32'h0);
        chk("clrA_never_rw",  {30'd0, uu_reg_write}, 32'b00);

        // clear[1] with en high: output still takes the old stage A content
        drive(vq[0], 11);
        @(negedge clk);
        clear = 2'b10; drive_null();
        @(negedge clk);
        chk("clrA_en_res", result_o, 32'h40100000);
        chk("clrA_en_rw",  {30'd0, uu_reg_write}, 32'b01);
        chk("clrA_en_rd1", {27'd0, uu_rd[1]}, 32'd11);
        clear = 2'b01; en = 0;
        @(negedge clk);
        chk("clrO_res", result_o, 32'h0);
        chk("clrO_rw",  {30'd0, uu_reg_write}, 32'b00);
        chk("clrO_p",   {31'd0, P_O_signal}, 32'd0);
        clear = 2'b00; en = 1;

        // asynchronous reset mid-stream
        drive(vq[1], 13);
        @(negedge clk); drive(vq[0], 14);
        @(negedge clk);
        chk("pre_rst_res", result_o, 32'h3F800000);
        #2 rst_n = 0;
        #1;
        chk("midrst_res", result_o, 32'h0);
        chk("midrst_flg", {27'd0, fflags_o}, 32'h0);
        chk("midrst_rw",  {30'd0, uu_reg_write}, 32'b00);
        chk("midrst_ps",  {17'd0, pipeline_signals_o}, 32'h0);
        drive_null();
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        chk("postrst_res1", result_o, 32'h0);
        @(negedge clk);
        chk("postrst_res2", result_o, 32'h0);
        chk("postrst_rw",   {30'd0, uu_reg_write}, 32'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fpmul_norm_round.md
# fpmul_norm_round

Back end of the FP multiply datapath. Consumes the raw, unrounded product from the upstream multiply pipeline: biased exponent sum, 48-bit significand product, sign and special-case flags. Normalizes it, denormalizes tiny results, rounds per `rm_i`, packs an IEEE-754 binary32 result and raises RISC-V `fflags`. It is a 2-stage pipeline sharing the execute-pipe `en`/`clear` scheme and exposing `uu_*` destination info for hazard/clear logic.

## Interface
- `addr_width`, 5, register address width
- `num_rds`, 2, pipeline stages reported on `uu_*`
- `clk` in 1: clock
- `rst_n` in 1: asynchronous active-low reset
- `en` in 1: pipeline advance; all stages hold when low
- `clear` in `num_rds`: flush; [1] = stage A, [0] = output stage
- `exp_i` in 10: signed biased exponent, `exp_a_unb + exp_b_unb + 127`
- `mant_i` in 48: 24×24 significand product, binary point between bits 46 and 45
- `sign_i`, `is_NaN_i`, `is_inf_i`, `is_zero_i` in 1 each: upstream result sign and special flags
- `nv_i` in 1: invalid operation from upstream (inf×0 or sNaN operand)
- `rm_i` in 3: resolved rounding mode, aligned with the data inputs
- `P_signal_i` in 1: side-band tag, piped alongside the data
- `pipeline_signals_i` in `exe_p_mux_bus_type`: control bundle, piped alongside the data
- `result_o` out 32: packed binary32 result
- `fflags_o` out 5: {NV, DZ, OF, UF, NX}
- `pipeline_signals_o` out `exe_p_mux_bus_type`
- `P_O_signal` out 1
- `uu_rd` out `[addr_width-1:0] [0:num_rds-1]`: [0] = stage A rd, [1] = output rd
- `uu_reg_write`, `uu_FP_reg_write` out `num_rds`: bit1 = stage A, bit0 = output stage

## Operation
- **Stage A (combinational from inputs, registered):**
  - Let m = `mant_i`, e = `exp_i`, sign-extended to 11 bits.
  - If m[47] = 1: shift m right by 1, OR the lost bit into sticky, e += 1.
  - Otherwise: lz = leading zeros of m[46:0]. Shift left by s = min(lz, max(e−1, 0)), e −= s.
  - If e < 1: shift right by min(1−e, 48), OR every lost bit into sticky, then set e = 0.
    - An exponent field of 0 means 2^−126 with no hidden 1.
  - Register m, e, sticky, sign, all flags, rm, `P_signal_i` and `pipeline_signals_i`.
- **Stage B (combinational from stage A registers, registered to outputs):**
  - frac = m[45:23], lsb = m[23], G = m[22], S = |m[21:0] | sticky.
  - Increment per rounding mode:
    - RNE: G&(S|lsb)
    - RTZ: 0
    - RDN: (G|S)&sign
    - RUP: (G|S)&~sign
    - RMM: G
    - Codes 5–7: treated as RNE.
  - A field of 0 with m[46] = 1 (rounded or exact) packs as exponent field 1.
  - A carry out of frac increments the exponent; a subnormal promotes to min normal naturally.
  - Rounded exponent ≥ 255 → overflow, OF = NX = 1:
    - ±inf for RNE/RMM, for RUP when positive, for RDN when negative.
    - Otherwise ±0x7F7FFFFF.
  - NX = G|S. UF = NX & (final exponent field == 0). DZ always 0.
  - m == 0 with no special flag → signed zero, no flags.
- **Special-case priority** (overrides all arithmetic): `is_NaN_i` → 0x7FC00000, NV = `nv_i`, other flags 0 → `is_inf_i` → {sign, 0x7F800000}, flags 0 → `is_zero_i` → {sign, 31'b0}, flags 0.
- **Register priority** per stage: `rst_n` > its `clear` bit > `en` > hold.
- `uu_*` is driven combinationally from the stage A and output registers' `pipeline_signals.rd/reg_write/FP_reg_write`.

## Timing
- Latency is 2 `en`-high edges: inputs sampled at edge N appear on outputs after edge N+1. Throughput is 1 per cycle.
- Reset values: `result_o`, `fflags_o`, `pipeline_signals_o`, `P_O_signal` and all stage A registers are 0, so `uu_*` reads 0.
- `clear[1]` zeroes stage A, including its control bundle. The output stage still loads stage A's old content on the same edge if `en` = 1.
- `clear[0]` zeroes the output registers. Simultaneous `clear[1]` and `clear[0]` zero both stages.
- `en` low: all registers hold and outputs stay stable. `clear` still acts when `en` is low.
- Asserting `rst_n` low mid-stream zeroes everything immediately. No partial result is emitted after release.

## Test plan
1. **1.5×1.5:** `exp_i`=127, `mant_i`=48'h900000000000, RNE → `result_o`=0x40100000, `fflags_o`=0, two `en` edges later.
2. **Tie rounding:** `exp_i`=127, `mant_i`=48'h400000400000, sign 0.
   - RNE → 0x3F800000, NX (0x01).
   - RUP → 0x3F800001.
   - RDN → 0x3F800000.
3. **Overflow:** `exp_i`=300, `mant_i`=48'h400000000000.
   - RNE → 0x7F800000, `fflags_o`=0x05.
   - RTZ → 0x7F7FFFFF, 0x05.
4. **Subnormal:** `mant_i`=48'h400000000000.
   - `exp_i`=−20 → 0x00000004, flags 0.
   - `exp_i`=−30: RNE → 0x00000000 with 0x03; RUP → 0x00000001 with 0x03.
5. **Specials:**
   - `is_NaN_i`=1, `nv_i`=1 → 0x7FC00000, 0x10.
   - `is_inf_i`=1, sign 1 → 0xFF800000, 0.
   - `is_zero_i`=1, sign 1 → 0x80000000.
6. **Pipeline control:**
   - Back-to-back ops with `en` toggling → each result held while `en` is low.
   - `clear[1]` one cycle after issue → op never appears; `uu_reg_write[1]` drops next cycle.
   - Reset mid-stream → all outputs 0.
